// File: rtl/bg_line_collector.sv
// bg_line_collector
// Collects the four per-column BG packets, keeps the winning pixel for each
// visible column and commits it into a double-buffered line buffer. The
// compositor reads the finished line from the bank not being written.
module bg_line_collector #(
  parameter  int HPIX    = 240,
  localparam int PKT_W   = 20,
  localparam int ENTRY_W = 22
) (
  input  logic               clock,
  input  logic               rst_b,
  input  logic [PKT_W-1:0]   bg_packet,
  input  logic [7:0]         hcount,
  input  logic               line_done,
  input  logic [7:0]         rd_col,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               wr_strobe,
  output logic [7:0]         wr_col,
  output logic [ENTRY_W-1:0] wr_entry
);

  localparam logic [7:0] HPIX_C = 8'(HPIX);

  // Position of the current packet within its column (packet index = bgno)
  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_t;

  // Line-buffer entry layout; an all-zero entry means "no BG pixel, use backdrop"
  typedef struct packed {
    logic        valid;
    logic [1:0]  prio;
    logic [1:0]  bgno;
    logic        direct;
    logic [15:0] colour;
  } entry_t;

  // Two banks of line storage, deliberately not reset
  logic [ENTRY_W-1:0] bank0_mem [HPIX];
  logic [ENTRY_W-1:0] bank1_mem [HPIX];

  phase_t             phase_q, phase_d;
  logic [7:0]         prev_hcount_q, prev_hcount_d;
  entry_t             best_q, best_d;
  logic               wr_bank_q, wr_bank_d;
  logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [7:0]         wr_col_q, wr_col_d;
  logic [ENTRY_W-1:0] wr_entry_q, wr_entry_d;

  logic               new_col;
  logic               accept;
  logic               commit;
  logic               pkt_vis;
  logic [1:0]         pkt_prio;
  entry_t             base;
  entry_t             cand;
  entry_t             merged;
  logic [ENTRY_W-1:0] rd_word;

  // Phase tracking: a change of hcount starts a new column, otherwise the
  // phase advances and sticks at 3 so surplus packets are ignored
  always_comb begin
    new_col       = (hcount != prev_hcount_q);
    prev_hcount_d = hcount;
    phase_d       = phase_q;
    if (new_col) begin
      phase_d = PH_0;
    end else begin
      case (phase_q)
        PH_0:    phase_d = PH_1;
        PH_1:    phase_d = PH_2;
        PH_2:    phase_d = PH_3;
        default: phase_d = PH_3;
      endcase
    end
    accept = new_col || (phase_q != PH_3);
  end

  // Winner selection: strictly lower priority replaces the current best, so
  // on a tie the earlier packet (lower bgno) is kept
  always_comb begin
    pkt_vis     = bg_packet[19];
    pkt_prio    = bg_packet[18:17];
    cand.valid  = 1'b1;
    cand.prio   = pkt_prio;
    cand.bgno   = phase_d;
    cand.direct = bg_packet[16];
    cand.colour = bg_packet[15:0];
    base        = new_col ? '0 : best_q;
    merged      = base;
    if (accept && pkt_vis && (!base.valid || (pkt_prio < base.prio))) begin
      merged = cand;
    end
    best_d = accept ? merged : best_q;
  end

  // Commit the column when its 4th packet arrives, but only for visible
  // columns; the 4th packet is folded in combinationally via 'merged'
  always_comb begin
    commit      = !new_col && (phase_q == PH_2) && (hcount < HPIX_C);
    wr_strobe_d = commit;
    wr_col_d    = wr_col_q;
    wr_entry_d  = wr_entry_q;
    if (commit) begin
      wr_col_d   = hcount;
      wr_entry_d = merged;
    end
  end

  // Bank swap on line_done; reads come from the bank not being written,
  // using the pre-swap selection in the swap cycle itself
  always_comb begin
    wr_bank_d = wr_bank_q ^ line_done;
    rd_word   = wr_bank_q ? bank0_mem[rd_col] : bank1_mem[rd_col];
    rd_data_d = (rd_col < HPIX_C) ? rd_word : '0;
  end

  // Line-buffer write port; a commit in the swap cycle lands in the old bank
  always_ff @(posedge clock) begin
    if (commit) begin
      if (wr_bank_q) begin
        bank1_mem[hcount] <= merged;
      end else begin
        bank0_mem[hcount] <= merged;
      end
    end
  end

  // Control and output registers; reset drops any in-flight column
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      phase_q       <= PH_0;
      prev_hcount_q <= 8'hFF;
      best_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_data_q     <= '0;
      wr_strobe_q   <= 1'b0;
      wr_col_q      <= '0;
      wr_entry_q    <= '0;
    end else begin
      phase_q       <= phase_d;
      prev_hcount_q <= prev_hcount_d;
      best_q        <= best_d;
      wr_bank_q     <= wr_bank_d;
      rd_data_q     <= rd_data_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_col_q      <= wr_col_d;
      wr_entry_q    <= wr_entry_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_col    = wr_col_q;
  assign wr_entry  = wr_entry_q;

endmodule
